// File: rtl/feature_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// feature_pingpong_buffer
//
// Double-buffered feature store sitting between the feature fetch stage and
// the compute array. The fetch stage fills one bank while compute reads the
// other. Each bank tracks its own EMPTY -> FILLING -> READY life cycle.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   wr_en/wr_addr/wr_data     write stream from fetch; wr_bank_sel picks bank
//   fill_done                 pulse: fetch into bank wr_bank_sel is complete
//   rd_en/rd_bank/rd_addr     compute-side read request (READY banks only)
//   rd_data/rd_valid          registered read result, 1-cycle latency
//   bank_release[1:0]         pulse per bank: compute is done with that bank
//   bank_ready[1:0]           per bank: bank is READY
//   bank0_count/bank1_count   accepted writes since the bank left EMPTY
//   wr_conflict               sticky: a write hit a READY bank
//   oob_err                   sticky: a write had wr_addr >= DEPTH
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// feature_pingpong_bank
//
// One bank: DEPTH x DW storage, its life-cycle FSM and its write counter.
// Writes arrive already qualified (address in range, bank not READY).
//
// Ports
//   wr_we/wr_addr/wr_data   qualified write into this bank
//   fill_hit                fill_done addressed to this bank
//   release_hit             bank_release for this bank
//   rd_addr/rd_word         asynchronous read of the storage array
//   ready                   bank is in READY
//   count                   accepted writes, saturating at DEPTH
// ---------------------------------------------------------------------------
module feature_pingpong_bank #(
    parameter int DW    = 128,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          fill_hit,
    input  logic          release_hit,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_word,
    output logic          ready,
    output logic [AW:0]   count
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;

    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    // Storage is deliberately left out of reset; only control state is cleared.
    logic [DW-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (wr_we && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
        case (state_q)
            // fill_done takes priority over the FILLING step, so a write and
            // fill_done in the same cycle store the word and land in READY.
            ST_EMPTY: begin
                if (fill_hit) begin
                    state_d = ST_READY;
                end else if (wr_we) begin
                    state_d = ST_FILLING;
                end
            end
            ST_FILLING: begin
                if (fill_hit) begin
                    state_d = ST_READY;
                end
            end
            // fill_done is ignored here, so release always wins.
            ST_READY: begin
                if (release_hit) begin
                    state_d = ST_EMPTY;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_word = mem[rd_addr];
    assign ready   = (state_q == ST_READY);
    assign count   = count_q;

endmodule

module feature_pingpong_buffer #(
    parameter int DW    = 128,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [14:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_bank_sel,
    input  logic          fill_done,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic [1:0]    bank_release,
    output logic [1:0]    bank_ready,
    output logic [AW:0]   bank0_count,
    output logic [AW:0]   bank1_count,
    output logic          wr_conflict,
    output logic          oob_err
);

    // One extra bit so DEPTH == 2^15 would still compare correctly.
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    logic                   wr_oob;
    logic                   wr_hits_ready;
    logic                   wr_ok;
    logic                   rd_hit;

    logic [1:0][DW-1:0]     bank_rd_word;
    logic [1:0][AW:0]       bank_count;

    logic [DW-1:0]          rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   wr_conflict_q, wr_conflict_d;
    logic                   oob_err_q, oob_err_d;

    // Write qualification: both error flags can fire on the same write.
    assign wr_oob        = wr_en && ({1'b0, wr_addr} >= DEPTH_W);
    assign wr_hits_ready = wr_en && bank_ready[wr_bank_sel];
    assign wr_ok         = wr_en && !wr_oob && !bank_ready[wr_bank_sel];

    // Read is judged against the current state, so a read in the same cycle
    // as the bank's release still returns data.
    assign rd_hit = rd_en && bank_ready[rd_bank];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        feature_pingpong_bank #(
            .DW    (DW),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .wr_we       (wr_ok && (wr_bank_sel == 1'(g))),
            .wr_addr     (wr_addr[AW-1:0]),
            .wr_data     (wr_data),
            .fill_hit    (fill_done && (wr_bank_sel == 1'(g))),
            .release_hit (bank_release[g]),
            .rd_addr     (rd_addr),
            .rd_word     (bank_rd_word[g]),
            .ready       (bank_ready[g]),
            .count       (bank_count[g])
        );
    end

    always_comb begin
        rd_valid_d    = rd_hit;
        rd_data_d     = rd_data_q;
        if (rd_hit) begin
            rd_data_d = bank_rd_word[rd_bank];
        end
        wr_conflict_d = wr_conflict_q | wr_hits_ready;
        oob_err_d     = oob_err_q | wr_oob;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_conflict_q <= 1'b0;
            oob_err_q     <= 1'b0;
        end else begin
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            wr_conflict_q <= wr_conflict_d;
            oob_err_q     <= oob_err_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wr_conflict = wr_conflict_q;
    assign oob_err     = oob_err_q;
    assign bank0_count = bank_count[0];
    assign bank1_count = bank_count[1];

endmodule

// File: doc/feature_pingpong_buffer.md
FEATURE_PINGPONG_BUFFER -- requirements
Module: feature_pingpong_buffer

Interface
REQ-001 SHALL have parameter DW, default 128, feature word width.
REQ-002 SHALL have parameter AW, default 8, per-bank address width.
REQ-003 SHALL have parameter DEPTH, default 256, words per bank, with DEPTH <= 2^AW.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  write strobe from the feature fetch stage.
REQ-007 wr_addr  in  15  write word address from the fetch stage.
REQ-008 wr_data  in  DW  write data.
REQ-009 wr_bank_sel  in  1  target bank, driven from the fetch stage memory select.
REQ-010 fill_done  in  1  single-cycle pulse; the fetch into bank wr_bank_sel is complete.
REQ-011 rd_en  in  1  compute-side read request.
REQ-012 rd_bank  in  1  bank to read.
REQ-013 rd_addr  in  AW  read word address.
REQ-014 rd_data  out  DW  registered read data.
REQ-015 rd_valid  out  1  pulse; rd_data carries the result of an accepted read.
REQ-016 bank_release  in  2  per-bank pulse; compute has finished with that bank.
REQ-017 bank_ready  out  2  per-bank; bank is in READY.
REQ-018 bank0_count, bank1_count  out  AW+1 each  accepted writes since the bank last left EMPTY.
REQ-019 wr_conflict  out  1  sticky; a write targeted a READY bank.
REQ-020 oob_err  out  1  sticky; a write had wr_addr >= DEPTH.

Function
REQ-021 SHALL hold two independent banks, each DEPTH x DW, with one write port and one read port per bank.
REQ-022 Each bank SHALL run an FSM with states EMPTY, FILLING and READY.
- EMPTY -> FILLING: on the first accepted write.
- EMPTY or FILLING -> READY: on fill_done with wr_bank_sel selecting the bank.
- READY -> EMPTY: on bank_release for that bank.
REQ-023 A write SHALL be accepted only when all of the following hold: wr_en=1, wr_addr < DEPTH, and the target bank is not READY.
REQ-024 An accepted write SHALL store wr_data at wr_addr[AW-1:0] and SHALL increment that bank's count, saturating at DEPTH.
REQ-025 A dropped write SHALL leave memory and count unchanged. wr_addr >= DEPTH SHALL set oob_err; target bank READY SHALL set wr_conflict; both SHALL be set if both conditions hold.
REQ-026 A write and fill_done to the same bank in the same cycle SHALL accept the write, then move the bank to READY.
REQ-027 fill_done to a READY bank SHALL be ignored. bank_release to a non-READY bank SHALL be ignored.
REQ-028 bank_release and fill_done to the same READY bank in the same cycle SHALL give EMPTY (release wins).
REQ-029 The transition to EMPTY SHALL clear that bank's count. bank_ready SHALL reflect the state on the cycle after the transition edge.
REQ-030 Reads SHALL have 1-cycle latency.
- rd_en=1 and bank rd_bank READY: rd_data = mem[rd_bank][rd_addr] and rd_valid=1 on the next cycle.
- Otherwise: rd_valid=0 and rd_data holds its value.
REQ-031 A read to a READY bank in the same cycle as its release SHALL still return valid data.
REQ-032 Both banks SHALL operate concurrently. Bank 0 may be READY and read while bank 1 fills, and vice versa.
REQ-033 wr_conflict and oob_err SHALL stay set until rst.

Reset
REQ-034 On rst: both banks EMPTY, bank_ready=2'b00, counts=0, rd_data=0, rd_valid=0, wr_conflict=0, oob_err=0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 rst mid-fill or mid-read SHALL discard state and the pending read. The first write after reset SHALL be handled as a write to an EMPTY bank.

Verification
REQ-037 Basic fill and read: write addr 0..3 of bank 0 with 0xA0..0xA3, then fill_done with sel=0 -> bank_ready=01 and bank0_count=4; rd_en to addr 2 -> rd_data=0xA2 with rd_valid=1 exactly one cycle later.
REQ-038 Ping-pong: bank 0 READY while bank 1 is written addr 5=0xB5 and fill_done sel=1, with a simultaneous read of bank 0 addr 1 -> 0xA1 returned, then bank_ready=11.
REQ-039 Write to a READY bank: write bank 0 while READY -> memory unchanged (readback returns the old value), wr_conflict=1 held, bank0_count unchanged.
REQ-040 Out-of-range write: wr_addr=DEPTH (256) -> oob_err=1, bank not moved to FILLING, count stays 0.
REQ-041 Same-cycle events: bank_release[0] with fill_done sel=0 on READY bank 0 -> EMPTY and count=0; write with fill_done on the same cycle -> write stored, then READY.
REQ-042 Reset mid-operation: assert rst with bank 1 FILLING and a read in flight -> next cycle rd_valid=0, rd_data=0, bank_ready=00, all counts and errors 0.
